// File: rtl/fsm_lab_pkg.sv
// Shared definitions for the FSM lab: run-pattern FSM states and run-detector constants.
package fsm_lab_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int RUN_CNT_W = 3;
  localparam logic [RUN_CNT_W-1:0] RUN_THRESH = 3'd4;

  // Saturating increment so that long runs never wrap the counter.
  function automatic logic [RUN_CNT_W-1:0] run_len_inc(input logic [RUN_CNT_W-1:0] n);
    return (n >= RUN_THRESH) ? RUN_THRESH : n + 3'd1;
  endfunction

endpackage

// File: rtl/run_model.sv
// Moore model of the four-in-a-row run detector; counts consecutive equal sampled bits.
module run_model
  import fsm_lab_pkg::*;
(
  input  logic clk,
  input  logic Reset,
  input  logic bit_in,
  output logic det
);

  logic [RUN_CNT_W-1:0] run_len;
  logic                 run_bit;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      run_len <= '0;
      run_bit <= 1'b0;
    end else if ((run_len == '0) || (bit_in != run_bit)) begin
      run_len <= 3'd1;
      run_bit <= bit_in;
    end else begin
      run_len <= run_len_inc(run_len);
    end
  end

  assign det = (run_len == RUN_THRESH);

endmodule

// File: rtl/run_pattern_gen.sv
// Serial run-pattern transmitter: emits (bit, length) runs one bit per clock and
// predicts the downstream run detector's output for the same cycle.
module run_pattern_gen
  import fsm_lab_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_bit,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             exp_det
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic             out_nxt, out_valid_nxt;
  logic             last;
  logic             load;

  // Ready in the final bit cycle lets a new run follow with no gap bit.
  assign last      = (remaining == LEN_W'(1));
  assign cmd_ready = (state == ST_IDLE) || last;
  assign load      = cmd_valid && cmd_ready && (cmd_len != '0);
  assign busy      = (state == ST_RUN);

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    out_nxt       = out;
    out_valid_nxt = out_valid;
    if (load) begin
      state_nxt     = ST_RUN;
      remaining_nxt = cmd_len;
      out_nxt       = cmd_bit;
      out_valid_nxt = 1'b1;
    end else if (state == ST_RUN) begin
      if (last) begin
        state_nxt     = ST_IDLE;
        remaining_nxt = '0;
        out_valid_nxt = 1'b0;
      end else begin
        remaining_nxt = remaining - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  run_model u_model (
    .clk   (clk),
    .Reset (Reset),
    .bit_in(out),
    .det   (exp_det)
  );

endmodule

// File: tb/tb_run_pattern_gen.sv
// Scoreboard bench for run_pattern_gen: accepted commands expand into an expected bit
// queue; a negedge monitor checks line, handshake and detector prediction every cycle.
module tb_run_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_bit;
  logic [3:0] cmd_len;
  logic       ser_out;
  logic       out_valid;
  logic       busy;
  logic       exp_det;

  int tests = 0;
  int fails = 0;

  bit exp_q[$];
  bit hist[$];
  bit line = 1'b0;

  run_pattern_gen #(.LEN_W(4)) dut (
    .clk      (clk),
    .Reset    (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_bit  (cmd_bit),
    .cmd_len  (cmd_len),
    .out      (ser_out),
    .out_valid(out_valid),
    .busy     (busy),
    .exp_det  (exp_det)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: a line bit seen in cycle k counts at the edge ending k, so the detector
  // is high in cycle k when the four previous cycles' line bits agree.
  always @(negedge clk) begin
    bit det_exp;
    if (rst) begin
      check("rst_out", int'(ser_out), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_cmd_ready", int'(cmd_ready), 1);
      check("rst_exp_det", int'(exp_det), 0);
      exp_q.delete();
      hist.delete();
      line = 1'b0;
    end else begin
      check("cmd_ready", int'(cmd_ready), int'(exp_q.size() <= 1));
      check("busy", int'(busy), int'(exp_q.size() != 0));
      check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      if (exp_q.size() != 0) line = exp_q.pop_front();
      check("out", int'(ser_out), int'(line));
      det_exp = (hist.size() >= 4) && (hist[0] == hist[1]) &&
                (hist[1] == hist[2]) && (hist[2] == hist[3]);
      check("exp_det", int'(exp_det), int'(det_exp));
      hist.push_back(line);
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input bit b, input logic [3:0] len);
    bit acc;
    bit done;
    done      = 1'b0;
    cmd_valid = 1'b1;
    cmd_bit   = b;
    cmd_len   = len;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        for (int k = 0; k < int'(len); k++) exp_q.push_back(b);
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit         b;
    logic [3:0] len;
    int         r;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_bit   = 1'b0;
    cmd_len   = '0;
    do_reset();

    idle(6);
    send(1'b1, 4'd4);
    idle(8);
    send(1'b1, 4'd3);
    send(1'b0, 4'd3);
    idle(3);
    send(1'b1, 4'd0);
    idle(3);
    send(1'b0, 4'd15);
    idle(6);

    send(1'b1, 4'd10);
    idle(4);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(8);

    for (int n = 0; n < 300; n++) begin
      b = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r == 0) len = 4'd0;
      else if (r < 3) len = 4'd15;
      else len = 4'($urandom_range(1, 15));
      send(b, len);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 5));
    end

    idle(20);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
